// File: rtl/uart_loader_pkg.sv
// Shared constants and types for the UART boot loader / memory arbiter slice.
package uart_loader_pkg;

  localparam logic [7:0] CMD_PTR  = 8'h00;
  localparam logic [7:0] CMD_DATA = 8'h01;
  localparam logic [7:0] CMD_CTRL = 8'h02;

  localparam int ERR_OVF   = 0;
  localparam int ERR_CKSUM = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CORE = 2'd1,
    LDR  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/ldr_fifo.sv
// First-word-fall-through write queue holding {address, data} pairs from the loader.
module ldr_fifo #(
  parameter int WIDTH = 30,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             clk,
  input  logic             RESET,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // NOTE: the storage array has no reset; pointers and count alone define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // NOTE: nonblocking assignments keep every register reading pre-edge values.
  always_ff @(posedge clk) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_loader_arb.sv
// UART command decoder feeding a write queue, plus a core/loader memory arbiter.
module uart_loader_arb
  import uart_loader_pkg::*;
#(
  parameter int ADDR_W     = 22,
  parameter int FIFO_DEPTH = 8,
  parameter int PRIO_LEVEL = 6
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              uart_write,
  input  logic [7:0]        uart_addr,
  input  logic [7:0]        uart_data,
  input  logic              uart_cksum_err,
  input  logic              core_req,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic              core_we,
  input  logic [7:0]        core_din,
  output logic              core_ack,
  output logic [7:0]        core_dout,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_din,
  input  logic              mem_ack,
  input  logic [7:0]        mem_dout,
  output logic              host_reset,
  output logic              loading,
  output logic [1:0]        status_err
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] PRIO_CNT = CW'(PRIO_LEVEL);

  arb_state_e        state;
  logic [ADDR_W-1:0] ptr;
  logic              cmd_ptr, cmd_data, cmd_ctrl;
  logic              q_push, q_pop, q_full, q_empty;
  logic [CW-1:0]     q_count;
  logic [ADDR_W+7:0] q_head;
  logic              core_req_eff;
  logic              ldr_go;
  logic [1:0]        next_err;

  assign cmd_ptr  = uart_write && (uart_addr == CMD_PTR);
  assign cmd_data = uart_write && (uart_addr == CMD_DATA);
  assign cmd_ctrl = uart_write && (uart_addr == CMD_CTRL);

  assign q_push       = cmd_data && !q_full;
  assign q_pop        = (state == LDR) && mem_ack;
  // A core held in reset must not win the bus nor see completions.
  assign core_req_eff = core_req && !host_reset;
  assign core_ack     = (state == CORE) && mem_ack && !host_reset;
  assign core_dout    = mem_dout;
  assign ldr_go       = (q_count >= PRIO_CNT) || (!core_req_eff && !q_empty);

  ldr_fifo #(
    .WIDTH(ADDR_W + 8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .RESET    (RESET),
    .push     (q_push),
    .push_data({ptr, uart_data}),
    .pop      (q_pop),
    .head     (q_head),
    .full     (q_full),
    .empty    (q_empty),
    .count    (q_count)
  );

  // NOTE: default first so every path assigns next_err and no latch is inferred.
  always_comb begin
    next_err = status_err;
    if (cmd_ctrl && uart_data[7]) next_err = '0;
    if (cmd_data && q_full)       next_err[ERR_OVF]   = 1'b1;
    if (uart_cksum_err)           next_err[ERR_CKSUM] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      ptr        <= '0;
      host_reset <= 1'b0;
      loading    <= 1'b0;
      status_err <= '0;
    end else begin
      // Dropped bytes still advance the pointer so later addresses stay aligned.
      if (cmd_ptr)       ptr <= {ptr[ADDR_W-9:0], uart_data};
      else if (cmd_data) ptr <= ptr + ADDR_W'(1);
      if (cmd_ctrl) begin
        host_reset <= uart_data[0];
        loading    <= uart_data[1];
      end
      status_err <= next_err;
    end
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      state    <= IDLE;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      mem_we   <= 1'b0;
      mem_din  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ldr_go) begin
            state               <= LDR;
            mem_req             <= 1'b1;
            mem_we              <= 1'b1;
            {mem_addr, mem_din} <= q_head;
          end else if (core_req_eff) begin
            state    <= CORE;
            mem_req  <= 1'b1;
            mem_addr <= core_addr;
            mem_we   <= core_we;
            mem_din  <= core_din;
          end
        end
        CORE, LDR: begin
          if (mem_ack) begin
            state   <= IDLE;
            mem_req <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_loader_arb.md
UART_LOADER_ARB -- requirements
Module: uart_loader_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 22, memory byte-address width.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, loader write-queue entries (power of 2).
REQ-003 SHALL have parameter PRIO_LEVEL, default 6, queue occupancy at which the loader overrides the core.
REQ-004 SHALL use one clock and a synchronous, active-high reset: clk input 1 is the system clock; RESET input 1 is the synchronous active-high reset.
REQ-005 SHALL have these UART-side inputs: uart_write 1, byte strobe from the packet demux; uart_addr 8, command address; uart_data 8, payload byte; uart_cksum_err 1, demux checksum flag.
REQ-006 SHALL have these core-side ports: core_req input 1, level request; core_addr input ADDR_W; core_we input 1; core_din input 8; core_ack output 1, one-cycle completion; core_dout output 8, read data.
REQ-007 SHALL have these memory-side ports: mem_req output 1; mem_addr output ADDR_W; mem_we output 1; mem_din output 8; mem_ack input 1, one-cycle completion; mem_dout input 8.
REQ-008 SHALL have these control and status outputs: host_reset output 1, holds the console core in reset; loading output 1, a load is in progress; status_err output 2, bit0 = queue overflow, bit1 = checksum error (both sticky).

Function
REQ-009 SHALL decode uart_addr on each uart_write cycle; addresses other than 0x00/0x01/0x02 SHALL be ignored.
REQ-010 SHALL, on 0x00, set ptr <= {ptr[ADDR_W-9:0], uart_data}, i.e. shift the pointer in MSB-first.
REQ-011 SHALL, on 0x01, enqueue {ptr, uart_data} and then set ptr <= ptr+1, wrapping modulo 2^ADDR_W.
REQ-012 SHALL, on 0x01 with the queue full, drop the byte, still increment ptr, and set status_err[0].
REQ-013 SHALL, on 0x02, set host_reset <= data[0] and loading <= data[1]; data[7]=1 SHALL clear status_err in the same cycle, and a simultaneous new error SHALL win.
REQ-014 SHALL set status_err[1] on any cycle in which uart_cksum_err=1.
REQ-015 SHALL treat a simultaneous enqueue and pop as leaving the occupancy count unchanged, with both operations taking effect.
REQ-016 SHALL implement an arbiter FSM with states IDLE, CORE, LDR.
REQ-017 SHALL, in IDLE, move to LDR if count>=PRIO_LEVEL; else to CORE if core_req=1; else to LDR if count>0; else stay in IDLE.
REQ-018 SHALL, in CORE, drive mem_req=1 with mem_addr/mem_we/mem_din from core_* as captured on entry, holding them stable until mem_ack.
REQ-019 SHALL, on mem_ack in CORE, assert core_ack=1 combinationally with core_dout=mem_dout, and return to IDLE.
REQ-020 SHALL, in LDR, drive mem_req=1, mem_we=1, with mem_addr/mem_din taken from the queue head.
REQ-021 SHALL, on mem_ack in LDR, pop the queue and return to IDLE.
REQ-022 SHALL register mem_req; it SHALL be low in IDLE, so consecutive transactions are separated by at least one idle cycle.
REQ-023 SHALL have these latencies: a 0x01 write at cycle N makes the entry visible at N+1, and mem_req rises at N+2 when the FSM was idle and the core was not requesting.
REQ-024 SHALL keep core_ack=0 except in the CORE ack cycle, and SHALL ignore mem_ack in IDLE.
REQ-025 SHALL assert no core_ack while host_reset=1; core_req SHALL be ignored in that condition.

Reset
REQ-026 SHALL, on RESET, set: state IDLE, mem_req 0, core_ack 0, queue empty, ptr 0, host_reset 0, loading 0, status_err 0.
REQ-027 SHALL, on RESET mid-transaction, drop mem_req in the next cycle and discard the in-flight request; a mem_ack arriving afterwards SHALL be ignored.

Structure
REQ-028 SHALL put command address constants (CMD_PTR=0x00, CMD_DATA=0x01, CMD_CTRL=0x02), the arbiter state enum and the status bit indices in shared package uart_loader_pkg.
REQ-029 SHALL implement the queue as sub-module ldr_fifo: synchronous, first-word-fall-through, width ADDR_W+8, outputs full/empty/count.

Verification
REQ-030 SHALL verify pointer load and data writes: 0x00 bytes 0x01,0x23,0x45 then 0x01 bytes 0xAA,0xBB -> memory writes 0x012345<-0xAA and 0x012346<-0xBB, each accepted on mem_ack.
REQ-031 SHALL verify overflow: 9 back-to-back 0x01 bytes with mem_ack held 0 -> 8 entries queued, status_err=01, ptr advanced by 9.
REQ-032 SHALL verify priority: core_req held with 6 entries queued -> LDR granted before CORE; with 2 entries -> CORE granted first, core_ack pulses with core_dout=mem_dout.
REQ-033 SHALL verify control: 0x02 byte 0x03 -> host_reset=1, loading=1, core_req ignored; byte 0x80 -> status_err cleared.
REQ-034 SHALL verify reset mid-LDR: RESET asserted with mem_req=1 -> next cycle mem_req=0, queue empty, late mem_ack produces no pop and no core_ack.
